// File: rtl/robot_pkg.sv
// robot_pkg: shared state encoding, action bundle constants and defaults for the robot controller.
package robot_pkg;
    typedef enum logic [2:0] {SEEK, FOLLOW, FWD_AFTER_LEFT, ROTATE, CLEAN, HALT} state_t;
    // Action bundle order is {front, turn, remove}.
    localparam logic [2:0] ACT_NONE   = 3'b000;
    localparam logic [2:0] ACT_FRONT  = 3'b100;
    localparam logic [2:0] ACT_TURN   = 3'b010;
    localparam logic [2:0] ACT_REMOVE = 3'b001;
    localparam int CLEAN_CYCLES_DEF = 3;
    localparam int STUCK_LIMIT_DEF  = 12;
endpackage

// File: rtl/robot_turn_watchdog.sv
// robot_turn_watchdog: counts consecutive turn-only cycles and trips at STUCK_LIMIT.
module robot_turn_watchdog #(
    parameter int STUCK_LIMIT = 12
) (
    input  logic clock,
    input  logic reset,
    input  logic front,
    input  logic turn,
    input  logic remove,
    output logic trip,
    output logic stuck
);
    localparam int W = $clog2(STUCK_LIMIT + 1);
    logic [W-1:0] cnt;
    logic turning;
    assign turning = turn && !front && !remove;
    // trip is combinational so the brain halts on the edge that ends the last allowed turn
    assign trip = turning && cnt == W'(STUCK_LIMIT - 1);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            stuck <= 1'b0;
        end else begin
            cnt   <= turning ? cnt + 1'b1 : '0;
            stuck <= stuck | trip;
        end
    end
endmodule

// File: rtl/robot_brain.sv
// robot_brain: left-hand wall-following controller with trash-removal handshake.
// Optional turn watchdog enabled by defining ROBOT_STUCK_WATCHDOG_EN.
module robot_brain
    import robot_pkg::*;
#(
    parameter int CLEAN_CYCLES = CLEAN_CYCLES_DEF
`ifdef ROBOT_STUCK_WATCHDOG_EN
    , parameter int STUCK_LIMIT = STUCK_LIMIT_DEF
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic head,
    input  logic left,
    input  logic under,
    input  logic barrier,
    output logic front,
    output logic turn,
    output logic remove,
    output logic halted,
    output logic stuck
);
    localparam int CW = $clog2(CLEAN_CYCLES + 1);
    state_t state, ret_state, geo_next;
    logic [1:0] rot_cnt;
    logic [CW-1:0] clean_cnt;
    logic [2:0] act, geo_act;
    logic seek_open, trip;

    assign {front, turn, remove} = act;
    assign seek_open = state == SEEK && !left;

    // Geometry decision for SEEK/FOLLOW/FWD_AFTER_LEFT once under/barrier are ruled out.
    always_comb begin
        geo_act  = state == FWD_AFTER_LEFT ? ACT_FRONT :
                   seek_open ? (head ? ACT_TURN : ACT_FRONT) :
                   (!left || head) ? ACT_TURN : ACT_FRONT;
        geo_next = state == FWD_AFTER_LEFT ? FOLLOW :
                   seek_open ? (head ? ROTATE : SEEK) :
                   !left ? FWD_AFTER_LEFT : head ? ROTATE : FOLLOW;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= SEEK;
            ret_state <= SEEK;
            rot_cnt   <= '0;
            clean_cnt <= '0;
            act       <= ACT_NONE;
            halted    <= 1'b0;
        end else if (trip) begin
            state  <= HALT;
            act    <= ACT_NONE;
            halted <= 1'b1;
        end else begin
            case (state)
                HALT: act <= ACT_NONE;
                ROTATE: begin
                    act     <= ACT_TURN;
                    rot_cnt <= rot_cnt - 2'd1;
                    if (rot_cnt == 2'd1) state <= FOLLOW;
                end
                CLEAN: begin
                    act       <= ACT_REMOVE;
                    clean_cnt <= clean_cnt + 1'b1;
                    if (clean_cnt == CW'(CLEAN_CYCLES - 1)) state <= ret_state;
                end
                default: begin
                    if (under) begin
                        state  <= HALT;
                        act    <= ACT_NONE;
                        halted <= 1'b1;
                    end else if (barrier) begin
                        act       <= ACT_REMOVE;
                        clean_cnt <= CW'(1);
                        ret_state <= state;
                        state     <= CLEAN_CYCLES > 1 ? CLEAN : state;
                    end else begin
                        act   <= geo_act;
                        state <= geo_next;
                        if (geo_next == ROTATE) rot_cnt <= 2'd2;
                    end
                end
            endcase
        end
    end

`ifdef ROBOT_STUCK_WATCHDOG_EN
    robot_turn_watchdog #(.STUCK_LIMIT(STUCK_LIMIT)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .front  (front),
        .turn   (turn),
        .remove (remove),
        .trip   (trip),
        .stuck  (stuck)
    );
`else
    assign trip  = 1'b0;
    assign stuck = 1'b0;
`endif
endmodule

// File: tb/tb_robot_brain.sv
// tb_robot_brain: scoreboard bench for robot_brain; expected actions are queued per driven edge.
module tb_robot_brain;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic head = 1'b0, left = 1'b0, under = 1'b0, barrier = 1'b0;
    logic front, turn, remove, halted, stuck;
    logic [4:0] obs;
    logic [4:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    // Observed/expected vector order: {front, turn, remove, halted, stuck}
    localparam logic [4:0] N = 5'b00000;
    localparam logic [4:0] F = 5'b10000;
    localparam logic [4:0] T = 5'b01000;
    localparam logic [4:0] R = 5'b00100;
    localparam logic [4:0] H = 5'b00010;
    localparam logic [4:0] S = 5'b00011;

    robot_brain dut (
        .clock   (clock),
        .reset   (reset),
        .head    (head),
        .left    (left),
        .under   (under),
        .barrier (barrier),
        .front   (front),
        .turn    (turn),
        .remove  (remove),
        .halted  (halted),
        .stuck   (stuck)
    );

    always #5 clock = ~clock;
    assign obs = {front, turn, remove, halted, stuck};

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b (front,turn,remove,halted,stuck)", tag, got, want);
        end
    endtask

    // Drive sensors for one edge, queue the action expected after it, then compare.
    task automatic step(input string tag, input logic h, input logic l, input logic u,
                        input logic b, input logic [4:0] want);
        @(negedge clock);
        head = h; left = l; under = u; barrier = b;
        exp_q.push_back(want);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) check({tag, "_empty"}, obs, 5'bxxxxx);
        else check(tag, obs, exp_q.pop_front());
    endtask

    // Asynchronous reset applied mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
        #1;
        check(tag, obs, N);
        @(posedge clock);
        #2;
        reset = 1'b1;
    endtask

    initial begin
        do_reset("reset");
        for (int i = 0; i < 5; i++) step("seek_front", 0, 0, 0, 0, F);
        step("seek_rot1", 1, 0, 0, 0, T);
        step("seek_rot2", 0, 1, 0, 0, T);
        step("seek_rot3", 0, 1, 0, 0, T);
        step("follow_front", 0, 1, 0, 0, F);
        step("left_turn", 0, 0, 0, 0, T);
        step("fwd_after_left", 0, 0, 0, 0, F);
        step("clean1", 0, 1, 0, 1, R);
        step("clean2", 0, 1, 0, 1, R);
        step("clean3", 0, 1, 0, 1, R);
        step("clean_return", 0, 1, 0, 0, F);
        step("clean_b1", 0, 1, 0, 1, R);
        step("clean_b2", 0, 1, 0, 0, R);
        do_reset("reset_mid_clean");
        step("seek_after_reset", 0, 0, 0, 0, F);
        step("under_barrier", 0, 0, 1, 1, H);
        for (int i = 0; i < 10; i++)
            step("halt_absorb", 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), H);
        do_reset("reset_from_halt");
`ifdef ROBOT_STUCK_WATCHDOG_EN
        for (int i = 0; i < 12; i++) step("wd_turn", 1, 1, 0, 0, T);
        for (int i = 0; i < 4; i++) step("wd_stuck", 1, 1, 0, 0, S);
`else
        for (int i = 0; i < 16; i++) step("spin_turn", 1, 1, 0, 0, T);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/robot_brain.md
# robot_brain

Left-hand wall-following controller for the pipe-cleaning robot: the decision side of the sensor/actuator interface driven by the world model. It samples the four world sensors (head, left, under, barrier) each robot clock and issues exactly one registered action (front, turn, remove) or none, including the multi-cycle trash-removal handshake the world expects. It sits under the world model, clocked by the robot step clock.

## Interface
- CLEAN_CYCLES, 3: consecutive cycles `remove` is held per trash block; must equal the world's removal depth.
- STUCK_LIMIT, 12: consecutive turn-only cycles before the watchdog halts (only with the watchdog macro).
- clock  in  1  robot step clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- head  in  1  wall or map edge directly ahead.
- left  in  1  wall or map edge on robot's left.
- under  in  1  robot is on black block (exit / end of pipe).
- barrier  in  1  trash block directly ahead.
- front  out  1  move one cell forward.
- turn  out  1  rotate 90° counter-clockwise (left).
- remove  out  1  work on trash ahead.
- halted  out  1  robot finished (under seen) or stuck; sticky until reset.
- stuck  out  1  watchdog trip; sticky until reset.

## Operation
- States: SEEK, FOLLOW, FWD_AFTER_LEFT, ROTATE, CLEAN, HALT. Reset state SEEK.
- Decision priority in every decision state: under > barrier > geometry.
- under=1 -> HALT, halted=1, all actions 0.
- barrier=1 -> CLEAN, remove=1, clean_cnt=1, ret_state=current state.
- SEEK, left=0: head=0 -> front, stay SEEK; head=1 -> turn, rot_cnt=2, ROTATE.
- SEEK, left=1: apply FOLLOW rules, move to FOLLOW.
- FOLLOW: left=0 -> turn, FWD_AFTER_LEFT; left=1,head=0 -> front; left=1,head=1 -> turn, rot_cnt=2, ROTATE.
- FWD_AFTER_LEFT: under/barrier rules, else front (even if left=0), -> FOLLOW. Prevents infinite left spin.
- ROTATE: turn each cycle, rot_cnt decrements; on the cycle rot_cnt reaches 0 -> FOLLOW. Three turns total = right turn. under/barrier not sampled in ROTATE.
- CLEAN: remove=1 while clean_cnt<CLEAN_CYCLES, incrementing; on cycle clean_cnt==CLEAN_CYCLES, remove=1, -> ret_state. Sensors ignored during CLEAN.
- HALT: absorbing; outputs 0 except halted (and stuck if tripped).
- Counter widths: rot_cnt 2 bits; clean_cnt $clog2(CLEAN_CYCLES+1) bits, no wrap.

## Timing
- Sensors sampled at rising edge n; action registered, valid from edge n to n+1; world consumes it at edge n+1. Latency one clock.
- At most one of front/turn/remove high in any cycle.
- Reset values: front=turn=remove=halted=stuck=0, state SEEK, all counters 0.
- Reset assertion mid-CLEAN or mid-ROTATE: outputs drop to 0 immediately (async), no partial state retained.
- under and barrier simultaneous: HALT, no remove.

## Configuration
- ROBOT_STUCK_WATCHDOG_EN defined: counter of consecutive cycles with turn=1 and front=remove=0; cleared by any front or remove; reaching STUCK_LIMIT -> HALT, stuck=1, halted=1.
- Undefined: no counter logic; stuck tied 0; robot may rotate forever in an enclosed cell.

## Structure
- Shared package robot_pkg: state enumeration (3-bit), sensor/action bundle constants, default CLEAN_CYCLES.
- One sub-module: robot_turn_watchdog (counter + trip flag), instantiated only under ROBOT_STUCK_WATCHDOG_EN.

## Test plan
- Reset, then head=left=under=barrier=0 for 5 cycles -> front=1 each cycle from first edge, state SEEK, turn=remove=0.
- SEEK, head=1,left=0 -> turn=1 for exactly 3 consecutive cycles, then with left=1,head=0 -> front=1.
- FOLLOW, left=0 for one edge then left=0 again -> turn=1 then front=1 (FWD_AFTER_LEFT), not two turns.
- barrier=1 in FOLLOW -> remove=1 for exactly 3 cycles, then with barrier=0,left=1,head=0 -> front=1; assert reset on 2nd remove cycle -> remove=0 immediately, SEEK after release.
- under=1 and barrier=1 same edge -> halted=1 next cycle, all actions 0 for 10 further cycles regardless of sensors.
- With ROBOT_STUCK_WATCHDOG_EN, STUCK_LIMIT=12, head=left=1 constant -> turn for 12 cycles, then stuck=halted=1, turn=0; without macro -> turn continues, stuck=0.
